// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator arithmetic unit.
//   DIV_WIDTH      default operand/result width of the sequential divider
//   DIV0_QUOTIENT  quotient reported for a zero divisor (all-ones, truncated
//                  to the divider width at the point of use)
//   div_state_e    divider FSM state encoding
// -----------------------------------------------------------------------------
package calc_pkg;

   localparam int DIV_WIDTH = 4;

   // Held 32 bits wide so a width cast at the use site gives all-ones for any
   // divider width up to 32.
   localparam logic [31:0] DIV0_QUOTIENT = '1;

   // Encoding chosen so that bit 0 is "busy" (CALC or DONE) and bit 1 is
   // "done" (DONE only). The status outputs are then plain flop bits.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_DONE = 2'b11
   } div_state_e;

endpackage : calc_pkg

// File: rtl/four_bit_divider_if.sv
// -----------------------------------------------------------------------------
// four_bit_divider_if
// Request/result bundle of the sequential divider.
//   start        request strobe, sampled by the divider only while idle
//   dividend     unsigned dividend, captured on an accepted start
//   divisor      unsigned divisor, captured on an accepted start
//   busy         divider is working or presenting a result
//   done         one-cycle strobe, results valid
//   quotient     registered quotient
//   remainder    registered remainder
//   div_by_zero  registered flag, last accepted divisor was zero
// Modports: master = requester (calculator decoder / bench), slave = divider.
// -----------------------------------------------------------------------------
interface four_bit_divider_if
   import calc_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );

endinterface : four_bit_divider_if

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration.
//   partial   (WIDTH+1)-bit partial remainder: working remainder with the next
//             dividend bit shifted in
//   divisor   unsigned divisor
//   next_rem  remainder after the trial subtraction / restore
//   q_bit     quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module div_step
   import calc_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH:0]   partial,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] next_rem,
   output logic             q_bit
);

   logic [WIDTH:0] trial;

   // The partial is always below 2*divisor, so both the trial (when it is
   // non-negative) and the restored partial (when it is not) fit in WIDTH bits.
   always_comb begin
      trial    = partial - {1'b0, divisor};
      q_bit    = ~trial[WIDTH];
      next_rem = q_bit ? trial[WIDTH-1:0] : partial[WIDTH-1:0];
   end

endmodule : div_step

// File: rtl/four_bit_divider.sv
// -----------------------------------------------------------------------------
// four_bit_divider
// Sequential unsigned restoring divider: one trial subtraction per clock,
// WIDTH iterations per division, one-cycle done strobe. A zero divisor skips
// the iterations and reports an all-ones quotient, the dividend as remainder
// and div_by_zero.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; abandons any operation in flight
//   bus    four_bit_divider_if.slave (start/operands in, status/results out)
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module four_bit_divider
   import calc_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   four_bit_divider_if.slave        bus
);

   localparam int               CNT_W     = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   div_state_e       state_q;
   div_state_e       state_d;

   // dvd_q starts as the latched dividend; each iteration shifts the consumed
   // MSB out and the new quotient bit in, so it ends holding the quotient.
   logic [WIDTH-1:0] dvd_q;
   logic [WIDTH-1:0] dsr_q;
   logic [WIDTH-1:0] rem_q;
   logic [CNT_W-1:0] cnt_q;

   logic [WIDTH-1:0] quot_q;
   logic [WIDTH-1:0] rmd_q;
   logic             dbz_q;

   logic             busy;
   logic             done;

   logic [WIDTH:0]   partial;
   logic [WIDTH-1:0] step_rem;
   logic             step_qbit;
   logic [WIDTH-1:0] step_quot;

   // ---------------------------------------------------------------------------
   // Iteration datapath
   // ---------------------------------------------------------------------------
   assign partial   = {rem_q, dvd_q[WIDTH-1]};
   assign step_quot = {dvd_q[WIDTH-2:0], step_qbit};

   div_step #(
      .WIDTH    (WIDTH)
   ) u_div_step (
      .partial  (partial),
      .divisor  (dsr_q),
      .next_rem (step_rem),
      .q_bit    (step_qbit)
   );

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: clocked state uses non-blocking assignment so every flop samples
      // the pre-edge values, independent of statement order.
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: default assignment first so every path drives state_d; a path
      // that left it unassigned would infer a latch.
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = (bus.divisor == '0) ? ST_DONE : ST_CALC;
            end
         end
         ST_CALC: begin
            if (cnt_q == LAST_ITER) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs (direct state bits, see the encoding in calc_pkg)
   // ---------------------------------------------------------------------------
   always_comb begin
      busy = state_q[0];
      done = state_q[1];
   end

   // ---------------------------------------------------------------------------
   // Operand, working and result registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dvd_q  <= '0;
         dsr_q  <= '0;
         rem_q  <= '0;
         cnt_q  <= '0;
         quot_q <= '0;
         rmd_q  <= '0;
         dbz_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  if (bus.divisor != '0) begin
                     dvd_q <= bus.dividend;
                     dsr_q <= bus.divisor;
                     rem_q <= '0;
                     cnt_q <= '0;
                     dbz_q <= 1'b0;
                  end else begin
                     // Results are final at once; the working registers are
                     // left alone because no iterations follow.
                     quot_q <= WIDTH'(DIV0_QUOTIENT);
                     rmd_q  <= bus.dividend;
                     dbz_q  <= 1'b1;
                  end
               end
            end
            ST_CALC: begin
               rem_q <= step_rem;
               dvd_q <= step_quot;
               cnt_q <= cnt_q + CNT_W'(1);
               // Publish on the last iteration so the results are valid in
               // the DONE cycle and stay untouched while iterating.
               if (cnt_q == LAST_ITER) begin
                  quot_q <= step_quot;
                  rmd_q  <= step_rem;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy        = busy;
   assign bus.done        = done;
   assign bus.quotient    = quot_q;
   assign bus.remainder   = rmd_q;
   assign bus.div_by_zero = dbz_q;

endmodule : four_bit_divider

// File: tb/tb_four_bit_divider.sv
// -----------------------------------------------------------------------------
// tb_four_bit_divider
// Directed self-checking bench for four_bit_divider. Inputs are driven 1 ns
// after a rising edge and outputs are sampled at the same point, so every
// sample sees the state settled by the preceding edge.
// -----------------------------------------------------------------------------
module tb_four_bit_divider;
   import calc_pkg::*;

   logic clk;
   logic rst_n;

   int   n_assert = 0;
   int   n_fail   = 0;

   int   lat;
   int   busy_n;
   logic seen_done;

   // Expected results of the held-start run: accepts at edges 0, 6, 12, 18.
   // Operands at edge k: dividend = (7k+3) mod 16, divisor = (k mod 5) + 1.
   //   k=0: 3/1  -> 3 r0   k=6: 13/2 -> 6 r1
   //   k=12: 7/3 -> 2 r1   k=18: 1/4 -> 0 r1
   logic [3:0] hold_q [4] = '{4'd3, 4'd6, 4'd2, 4'd0};
   logic [3:0] hold_r [4] = '{4'd0, 4'd1, 4'd1, 4'd1};

   // Hand-computed plain divisions.
   logic [3:0] vec_a [3] = '{4'd15, 4'd2, 4'd0};
   logic [3:0] vec_b [3] = '{4'd1,  4'd7, 4'd5};
   logic [3:0] vec_q [3] = '{4'd15, 4'd0, 4'd0};
   logic [3:0] vec_r [3] = '{4'd0,  4'd2, 4'd0};

   four_bit_divider_if #(.WIDTH(4)) bus ();

   four_bit_divider #(
      .WIDTH (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      n_assert++;
      assert (observed === expected) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic check_outputs(input string tag, input logic busy, input logic done,
                                input logic [3:0] q, input logic [3:0] r,
                                input logic dbz);
      check({tag, " busy"},        bus.busy,        busy);
      check({tag, " done"},        bus.done,        done);
      check({tag, " quotient"},    bus.quotient,    q);
      check({tag, " remainder"},   bus.remainder,   r);
      check({tag, " div_by_zero"}, bus.div_by_zero, dbz);
   endtask

   // Issue one request from idle and wait for done. lat counts rising edges
   // from the accept edge to the first sample showing done; busy_n counts the
   // samples, from the accept edge to done inclusive, that show busy. Operands
   // are scrambled right after the accept edge so only latched copies matter.
   task automatic run_div(input logic [3:0] a, input logic [3:0] b,
                          output int lat_o, output int busy_o);
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      tick();
      bus.start    = 1'b0;
      bus.dividend = ~a;
      bus.divisor  = ~b;
      lat_o  = 0;
      busy_o = 0;
      while (!bus.done && lat_o < 20) begin
         busy_o += int'(bus.busy);
         tick();
         lat_o++;
      end
      busy_o += int'(bus.busy);
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (3) tick();
      check_outputs("reset", 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
      rst_n = 1'b1;
      tick();
      check_outputs("idle after reset", 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);

      // 13 / 3: done four edges after accept, busy for five cycles.
      run_div(4'd13, 4'd3, lat, busy_n);
      check("13/3 latency", lat, 4);
      check("13/3 busy cycles", busy_n, 5);
      check_outputs("13/3 result", 1'b1, 1'b1, 4'd4, 4'd1, 1'b0);
      tick();
      check_outputs("13/3 back to idle", 1'b0, 1'b0, 4'd4, 4'd1, 1'b0);

      for (int i = 0; i < 3; i++) begin
         run_div(vec_a[i], vec_b[i], lat, busy_n);
         check($sformatf("%0d/%0d latency", vec_a[i], vec_b[i]), lat, 4);
         check_outputs($sformatf("%0d/%0d result", vec_a[i], vec_b[i]),
                       1'b1, 1'b1, vec_q[i], vec_r[i], 1'b0);
         tick();
      end

      // 5 / 0: done in the cycle right after the accept edge.
      run_div(4'd5, 4'd0, lat, busy_n);
      check("5/0 latency", lat, 0);
      check("5/0 busy cycles", busy_n, 1);
      check_outputs("5/0 result", 1'b1, 1'b1, 4'hF, 4'd5, 1'b1);
      tick();
      check_outputs("5/0 back to idle", 1'b0, 1'b0, 4'hF, 4'd5, 1'b1);

      run_div(4'd9, 4'd2, lat, busy_n);
      check("9/2 latency", lat, 4);
      check_outputs("9/2 result", 1'b1, 1'b1, 4'd4, 4'd1, 1'b0);
      tick();

      // start held high for 20 edges with operands changing every cycle.
      for (int k = 0; k < 24; k++) begin
         bus.start    = (k < 20);
         bus.dividend = 4'((k * 7 + 3) % 16);
         bus.divisor  = 4'((k % 5) + 1);
         tick();
         check($sformatf("hold edge %0d busy", k), bus.busy, (k % 6) != 5);
         check($sformatf("hold edge %0d done", k), bus.done, (k % 6) == 4);
         if ((k % 6) == 4) begin
            check($sformatf("hold edge %0d quotient", k), bus.quotient, hold_q[k / 6]);
            check($sformatf("hold edge %0d remainder", k), bus.remainder, hold_r[k / 6]);
         end
      end
      bus.start = 1'b0;

      // Reset during the second CALC cycle of 14 / 3, with 5/0 results
      // still held so the clearing of quotient and remainder is visible.
      run_div(4'd5, 4'd0, lat, busy_n);
      tick();
      bus.start    = 1'b1;
      bus.dividend = 4'd14;
      bus.divisor  = 4'd3;
      tick();
      bus.start = 1'b0;
      tick();
      check_outputs("14/3 before abort", 1'b1, 1'b0, 4'hF, 4'd5, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check_outputs("reset mid-calc", 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
      seen_done = 1'b0;
      repeat (2) begin
         tick();
         seen_done |= bus.done;
      end
      rst_n = 1'b1;
      repeat (8) begin
         tick();
         seen_done |= bus.done;
      end
      check("no done after abort", seen_done, 1'b0);
      check_outputs("idle after abort", 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);

      run_div(4'd14, 4'd3, lat, busy_n);
      check("14/3 latency", lat, 4);
      check_outputs("14/3 result", 1'b1, 1'b1, 4'd4, 4'd2, 1'b0);
      tick();

      // Exhaustive sweep: invariant and latency for every operand pair.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            run_div(4'(a), 4'(b), lat, busy_n);
            if (b == 0) begin
               check($sformatf("sweep %0d/0 latency", a), lat, 0);
               check($sformatf("sweep %0d/0 quotient", a), bus.quotient, 4'hF);
               check($sformatf("sweep %0d/0 remainder", a), bus.remainder, a);
               check($sformatf("sweep %0d/0 div_by_zero", a), bus.div_by_zero, 1'b1);
            end else begin
               check($sformatf("sweep %0d/%0d latency", a, b), lat, 4);
               check($sformatf("sweep %0d/%0d q*d+r", a, b),
                     int'(bus.quotient) * b + int'(bus.remainder), a);
               check($sformatf("sweep %0d/%0d r<d", a, b),
                     int'(bus.remainder) < b, 1'b1);
               check($sformatf("sweep %0d/%0d div_by_zero", a, b), bus.div_by_zero, 1'b0);
            end
            tick();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_four_bit_divider

// File: doc/four_bit_divider.md
# four_bit_divider

Sequential 4-bit unsigned restoring divider for the calculator datapath. It is the multi-cycle counterpart to the combinational add/subtract path: it performs one trial subtraction per clock to produce quotient and remainder. The operation is requested with a start pulse, and completion is signalled with a one-cycle `done` strobe. It sits beside the adder-subtractor in the calculator's arithmetic unit and is selected by the operation decoder for the divide key.

## Interface
- `WIDTH`, 4, operand/result width; iteration count equals `WIDTH` (only 4 verified)
- `clk`  input  1  single clock, rising edge
- `rst_n`  input  1  reset, asynchronous assert, active-low
- `start`  input  1  request; sampled only in IDLE
- `dividend`  input  WIDTH  unsigned dividend, captured on accepted start
- `divisor`  input  WIDTH  unsigned divisor, captured on accepted start
- `busy`  output  1  high in CALC and DONE
- `done`  output  1  one-cycle strobe, results valid
- `quotient`  output  WIDTH  registered quotient
- `remainder`  output  WIDTH  registered remainder
- `div_by_zero`  output  1  registered; set when the captured divisor was 0

## Operation
- Reset (`rst_n` low, any time, including mid-CALC):
  - state IDLE
  - `busy`, `done`, `div_by_zero` cleared to 0
  - `quotient` and `remainder` cleared to 0
  - iteration counter cleared to 0
  - any in-flight operation is abandoned, with no partial result and no `done`
- States:
  - IDLE:
    - `start`=1 with divisor≠0 → CALC: latch operands, clear the working remainder, counter=0
    - `start`=1 with divisor=0 → DONE: `quotient`=all-ones (4'hF), `remainder`=dividend, `div_by_zero`=1
    - `start`=0 → stay in IDLE
  - CALC, one iteration per clock:
    - shift the next dividend bit (MSB first) into the working remainder to form a (WIDTH+1)-bit partial
    - trial = partial − divisor, computed WIDTH+1 bits wide
    - trial non-negative (MSB 0): remainder=trial and the quotient bit is 1
    - otherwise keep the partial and the quotient bit is 0
    - after iteration `WIDTH`, go to DONE
  - DONE: `done`=1 for exactly one cycle, then → IDLE unconditionally.
- `start` in CALC or DONE is ignored, not queued. `start` held high continuously begins a new operation on the first IDLE cycle.
- `quotient`, `remainder` and `div_by_zero` hold their values from DONE until the next accepted start. `div_by_zero` clears on any accepted start with a non-zero divisor.
- Operand inputs may change freely after the accept edge; only the latched copies are used.
- Invariant for divisor≠0: dividend = quotient·divisor + remainder, with remainder < divisor.

## Timing
- Accept edge E0: `start` high in IDLE. `busy` is high from the cycle after E0.
- Normal division:
  - iterations complete on edges E1..E4
  - `done`=1 and results valid in the cycle after E4
  - E5 returns to IDLE with `busy` low
  - earliest next accept is E6
- Divide by zero: `done`=1 in the cycle after E0, and IDLE after E1.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Throughput: one division per `WIDTH`+2 cycles.

## Structure
- Shared package `calc_pkg` holds:
  - the state encoding (IDLE, CALC, DONE as a 2-bit enum)
  - the `WIDTH` default constant
  - `DIV0_QUOTIENT` (all-ones)
- One combinational sub-module, `div_step`:
  - inputs: partial remainder, divisor
  - outputs: next remainder, quotient bit
  - implements the (WIDTH+1)-bit trial subtraction and restore mux
- The top holds the FSM, the counter, the operand and working registers, and the output registers.

## Test plan
- 13 / 3:
  - pulse `start`, then `done` appears exactly 4 cycles after the accept edge
  - quotient=4, remainder=1, `div_by_zero`=0, `busy` high for 5 cycles
- 15 / 1 → quotient=15, remainder=0; 2 / 7 → quotient=0, remainder=2; 0 / 5 → quotient=0, remainder=0.
- 5 / 0:
  - `done` appears 1 cycle after the accept edge
  - quotient=4'hF, remainder=5, `div_by_zero`=1
  - a following 9 / 2 gives quotient=4, remainder=1, `div_by_zero`=0
- Hold `start` high for 20 cycles with changing operands:
  - operations are accepted only in IDLE, exactly every 6 cycles
  - each result matches the operands present at its accept edge
- Assert `rst_n` low during the 2nd CALC cycle of 14 / 3:
  - all outputs go to 0 immediately, no `done` appears
  - after release, 14 / 3 gives quotient=4, remainder=2
- Exhaustive sweep of all 256 operand pairs checks the quotient/remainder invariant and `done` latency.
